// File: rtl/gate_align_buffer.sv
// gate_align_buffer: DEPTH-entry alignment FIFO holding LANES gate values
// per entry between the sigmoid stage and the h_t = o_t * tanh(c_t) multiplier.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            synchronous clear of pointers and count (data kept)
//   wr_valid/wr_data push request and LANES*DW gate values
//   rd_req           pop request from the tanh(c_t) stage
//   rd_data/rd_valid registered popped entry and its one-cycle strobe
//   count/full/empty occupancy derived from the registered count
//   ovf_err/udf_err  sticky dropped-push / empty-pop flags
//   err_clr          clears both sticky flags
module gate_align_buffer #(
    parameter int DW    = 16,
    parameter int LANES = 1,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [LANES*DW-1:0]   wr_data,
    input  logic                  rd_req,
    output logic [LANES*DW-1:0]   rd_data,
    output logic                  rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf_err,
    output logic                  udf_err,
    input  logic                  err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [LANES*DW-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wp;
    logic [AW-1:0]       r_rp;
    logic [AW:0]         r_count;
    logic [LANES*DW-1:0] r_rd_data;
    logic                r_rd_valid;
    logic                r_ovf;
    logic                r_udf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;
    logic w_udf_set;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Pop is decided on the pre-edge occupancy, so an empty buffer never
    // forwards the entry being written in the same cycle.
    assign w_push    = !flush && wr_valid && (!w_full || rd_req);
    assign w_pop     = !flush && rd_req && !w_empty;
    assign w_ovf_set = !flush && wr_valid && w_full && !rd_req;
    assign w_udf_set = !flush && rd_req && w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (flush) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp      <= r_rp + AW'(1);
                r_rd_data <= r_mem[r_rp];
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf && !err_clr) || w_ovf_set;
            r_udf <= (r_udf && !err_clr) || w_udf_set;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign ovf_err  = r_ovf;
    assign udf_err  = r_udf;

endmodule

// File: tb/tb_gate_align_buffer.sv
// tb_gate_align_buffer: directed and randomized checks of gate_align_buffer
// against a queue-based reference model (LANES=4, DW=16, DEPTH=4).
module tb_gate_align_buffer;

    localparam int DW    = 16;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int W     = LANES*DW;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         wr_valid;
    logic [W-1:0] wr_data;
    logic         rd_req;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic [2:0]   count;
    logic         full;
    logic         empty;
    logic         ovf_err;
    logic         udf_err;
    logic         err_clr;

    gate_align_buffer #(
        .DW(DW),
        .LANES(LANES),
        .DEPTH(DEPTH)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .rd_req(rd_req),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .count(count),
        .full(full),
        .empty(empty),
        .ovf_err(ovf_err),
        .udf_err(udf_err),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    logic [W-1:0] m_q[$];
    logic [W-1:0] m_rd;
    logic         m_rv;
    logic         m_ovf;
    logic         m_udf;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        chk({tag, ".rd_valid"}, W'(rd_valid), W'(m_rv));
        chk({tag, ".rd_data"}, rd_data, m_rd);
        chk({tag, ".count"}, W'(count), W'(sz));
        chk({tag, ".full"}, W'(full), W'(sz == DEPTH));
        chk({tag, ".empty"}, W'(empty), W'(sz == 0));
        chk({tag, ".ovf"}, W'(ovf_err), W'(m_ovf));
        chk({tag, ".udf"}, W'(udf_err), W'(m_udf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rd  = '0;
        m_rv  = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock: drive inputs, advance model on the edge, check #1 later.
    task automatic step(input string tag, input logic wv, input logic [W-1:0] wd,
                        input logic rr, input logic fl, input logic ec);
        int  sz;
        logic nov;
        logic nud;
        wr_valid = wv;
        wr_data  = wd;
        rd_req   = rr;
        flush    = fl;
        err_clr  = ec;
        @(posedge clk);
        sz  = m_q.size();
        nov = 1'b0;
        nud = 1'b0;
        if (fl) begin
            m_q.delete();
            m_rv = 1'b0;
        end else begin
            nov  = wv && (sz == DEPTH) && !rr;
            nud  = rr && (sz == 0);
            m_rv = 1'b0;
            if (rr && sz > 0) begin
                m_rd = m_q.pop_front();
                m_rv = 1'b1;
            end
            if (wv && (sz < DEPTH || rr)) m_q.push_back(wd);
        end
        m_ovf = (m_ovf && !ec) || nov;
        m_udf = (m_udf && !ec) || nud;
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        step("idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [W-1:0] held;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_req   = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // basic ordering
        step("b_push", 1'b1, W'('h0011), 1'b0, 1'b0, 1'b0);
        step("b_push", 1'b1, W'('h0022), 1'b0, 1'b0, 1'b0);
        step("b_push", 1'b1, W'('h0033), 1'b0, 1'b0, 1'b0);
        chk("b_count3", W'(count), W'(3));
        step("b_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("b_pop1", rd_data, W'('h0011));
        step("b_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("b_pop2", rd_data, W'('h0022));
        step("b_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("b_pop3", rd_data, W'('h0033));
        chk("b_empty", W'(empty), W'(1));
        idle();
        chk("b_rv_pulse", W'(rd_valid), W'(0));

        // full and overflow
        for (int i = 1; i <= 5; i++)
            step("f_push", 1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        chk("f_full", W'(full), W'(1));
        chk("f_ovf", W'(ovf_err), W'(1));
        for (int i = 1; i <= 4; i++) begin
            step("f_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("f_pop_data", rd_data, W'(i));
        end
        step("f_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("f_ovf_clr", W'(ovf_err), W'(0));

        // simultaneous push/pop at full
        for (int i = 'hA; i <= 'hD; i++)
            step("s_fill", 1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        step("s_both", 1'b1, W'('hE), 1'b1, 1'b0, 1'b0);
        chk("s_oldest", rd_data, W'('hA));
        chk("s_count4", W'(count), W'(4));
        for (int i = 'hB; i <= 'hE; i++) begin
            step("s_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("s_pop_data", rd_data, W'(i));
        end

        // underflow with simultaneous push on empty
        held = rd_data;
        step("u_both", 1'b1, W'('h0055), 1'b1, 1'b0, 1'b0);
        chk("u_rv0", W'(rd_valid), W'(0));
        chk("u_hold", rd_data, held);
        chk("u_udf", W'(udf_err), W'(1));
        step("u_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("u_data", rd_data, W'('h0055));
        step("u_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("u_udf_clr", W'(udf_err), W'(0));

        // wrap then flush
        step("w_prime", 1'b1, W'('h100), 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++)
            step("w_pp", 1'b1, W'('h100 + i), 1'b1, 1'b0, 1'b0);
        step("w_push", 1'b1, W'('h200), 1'b0, 1'b0, 1'b0);
        chk("w_count2", W'(count), W'(2));
        held = rd_data;
        step("w_flush", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("w_fl_count", W'(count), W'(0));
        chk("w_fl_rv", W'(rd_valid), W'(0));
        chk("w_fl_hold", rd_data, held);
        step("w_after", 1'b1, W'('h300), 1'b0, 1'b0, 1'b0);
        step("w_after_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("w_after_data", rd_data, W'('h300));

        // multi-lane ordering
        step("m_push", 1'b1, 64'h4444_3333_2222_1111, 1'b0, 1'b0, 1'b0);
        step("m_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("m_lanes", rd_data, 64'h4444_3333_2222_1111);

        // asynchronous reset mid-cycle
        step("r_push", 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1'b0);
        step("r_ovf", 1'b1, '0, 1'b0, 1'b0, 1'b0);
        step("r_pop", 1'b1, W'(9), 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 2) != 0),
                 {$urandom, $urandom},
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
